// File: rtl/spi_flash_reader.sv
`timescale 1ns/1ps
// spi_flash_reader: Wishbone slave that serves 32-bit reads from an SPI NOR
// flash using the 0x03 READ command (mode 0, MSB first). Writes are acked
// and dropped.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, async active-high reset
//   wbs_cyc_i/stb_i/we_i      Wishbone request qualifiers
//   wbs_sel_i, wbs_dat_i      ignored
//   wbs_adr_i                 byte address; [31:24] selects this block, [23:2] flash word
//   wbs_ack_o, wbs_dat_o      single-cycle ack, little-endian read data
//   flash_csb/clk/io0         SPI chip select (low), clock, MOSI
//   flash_io1                 SPI MISO
module spi_flash_reader #(
    parameter int unsigned CLK_DIV  = 2,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    localparam int unsigned CNT_W = 9;
    localparam int unsigned BIT_W = 6;
    localparam int unsigned TX_W  = 64;
    localparam int unsigned RX_W  = 32;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(63);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [TX_W-1:0]   tx_q, tx_d;
    logic [RX_W-1:0]   rx_q, rx_d;
    logic [31:0]       dat_q, dat_d;
    logic              csb_q, csb_d;
    logic              sck_q, sck_d;
    logic              io0_q, io0_d;
    logic              ack_q, ack_d;

    logic              req_c;
    logic              unused_ok;

    // Byte selects, write data and the byte offset within a word carry no meaning here.
    assign unused_ok = ^{wbs_sel_i, wbs_dat_i, wbs_adr_i[1:0]};

    assign req_c = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_ADR[31:24]);

    // Next-state and output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dat_d   = dat_q;
        csb_d   = csb_q;
        sck_d   = sck_q;
        io0_d   = io0_q;
        ack_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // The !ack_q guard keeps a write held through its ack from acking twice.
                if (req_c && !ack_q) begin
                    if (wbs_we_i) begin
                        ack_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        csb_d   = 1'b0;
                        sck_d   = 1'b0;
                        cnt_d   = '0;
                        bit_d   = '0;
                        tx_d    = {8'h03, wbs_adr_i[23:2], 2'b00, 32'h0};
                        io0_d   = tx_d[TX_W-1];
                    end
                end
            end

            SHIFT: begin
                if (!wbs_cyc_i) begin
                    // Master abandoned the cycle: close the flash command quietly.
                    state_d = GAP;
                    csb_d   = 1'b1;
                    sck_d   = 1'b0;
                    io0_d   = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        // Rising SCK: capture MISO.
                        rx_d = {rx_q[RX_W-2:0], flash_io1};
                    end else if (bit_q == LAST_BIT) begin
                        // 64th falling SCK: transfer complete, bytes arrived B0 first.
                        state_d = GAP;
                        csb_d   = 1'b1;
                        sck_d   = 1'b0;
                        io0_d   = 1'b0;
                        ack_d   = 1'b1;
                        dat_d   = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                    end else begin
                        // Falling SCK: present the next MOSI bit.
                        bit_d = bit_q + BIT_W'(1);
                        tx_d  = {tx_q[TX_W-2:0], 1'b0};
                        io0_d = tx_q[TX_W-2];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            GAP: begin
                // Minimum chip-select high time between commands.
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                csb_d   = 1'b1;
                sck_d   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dat_q   <= '0;
            csb_q   <= 1'b1;
            sck_q   <= 1'b0;
            io0_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dat_q   <= dat_d;
            csb_q   <= csb_d;
            sck_q   <= sck_d;
            io0_q   <= io0_d;
            ack_q   <= ack_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign flash_csb = csb_q;
    assign flash_clk = sck_q;
    assign flash_io0 = io0_q;

endmodule
